// File: rtl/password_checker.sv
// Keypad password checker: turns the debounced key stream into single key events,
// buffers BCD digits and compares them against a stored password with timed outcomes.
module password_checker #(
  parameter int          PW_LEN      = 4,
  parameter logic [31:0] PASSWORD    = 32'h0000_1234,
  parameter int          DEB_CYCLES  = 2,
  parameter int          OPEN_CYCLES = 50_000_000,
  parameter int          ERR_CYCLES  = 25_000_000,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCK_CYCLES = 250_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  value,
  input  logic        enable,
  output logic        key_ack,
  output logic [3:0]  digit_count,
  output logic [31:0] entry,
  output logic        unlock,
  output logic        error,
  output logic        lockout,
  output logic [3:0]  fail_count
);

  localparam int MAX_T0  = (OPEN_CYCLES > ERR_CYCLES) ? OPEN_CYCLES : ERR_CYCLES;
  localparam int MAX_T   = (MAX_T0 > LOCK_CYCLES) ? MAX_T0 : LOCK_CYCLES;
  localparam int TW      = $clog2(MAX_T) + 1;
  localparam int DW      = $clog2(DEB_CYCLES + 1);
  localparam int PW_BITS = 4 * PW_LEN;

  localparam logic [TW-1:0]      OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0]      ERR_LOAD  = TW'(ERR_CYCLES - 1);
  localparam logic [TW-1:0]      LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [DW-1:0]      DEB_MAX   = DW'(DEB_CYCLES);
  localparam logic [DW-1:0]      DEB_FIRE  = DW'(DEB_CYCLES - 1);
  localparam logic [3:0]         PW_LEN4   = 4'(PW_LEN);
  localparam logic [3:0]         MAX_FAIL4 = 4'(MAX_FAIL);
  localparam logic [PW_BITS-1:0] PW_VALUE  = PASSWORD[PW_BITS-1:0];

  localparam logic [2:0] S_ENTRY   = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_OPEN    = 3'd2;
  localparam logic [2:0] S_FAIL    = 3'd3;
  localparam logic [2:0] S_LOCKOUT = 3'd4;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;

  logic [DW-1:0] deb_cnt;
  logic          armed;
  logic          key_event;

  logic [2:0]    state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [31:0]   entry_nxt;
  logic [3:0]    count_nxt;
  logic [3:0]    fail_nxt;
  logic [3:0]    fail_inc;
  logic          ack_nxt;
  logic          is_digit, is_clear, is_enter;
  logic          match;
  logic          timer_zero;

  // The event fires on the cycle the counter would reach DEB_CYCLES; armed blocks repeats while held.
  assign key_event = enable && armed && (deb_cnt == DEB_FIRE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_cnt <= '0;
      armed   <= 1'b1;
    end else if (!enable) begin
      deb_cnt <= '0;
      armed   <= 1'b1;
    end else begin
      if (deb_cnt != DEB_MAX)
        deb_cnt <= deb_cnt + DW'(1);
      if (key_event)
        armed <= 1'b0;
    end
  end

  assign is_digit   = (value <= 4'd9);
  assign is_clear   = (value == KEY_CLEAR);
  assign is_enter   = (value == KEY_ENTER);
  assign match      = (digit_count == PW_LEN4) && (entry[PW_BITS-1:0] == PW_VALUE);
  assign timer_zero = (timer == '0);
  assign fail_inc   = fail_count + 4'd1;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    entry_nxt = entry;
    count_nxt = digit_count;
    fail_nxt  = fail_count;
    ack_nxt   = 1'b0;

    case (state)
      S_ENTRY: begin
        if (key_event) begin
          if (is_digit) begin
            if (digit_count < PW_LEN4) begin
              entry_nxt = {entry[27:0], value};
              count_nxt = digit_count + 4'd1;
              ack_nxt   = 1'b1;
            end
          end else if (is_clear) begin
            entry_nxt = '0;
            count_nxt = '0;
            ack_nxt   = 1'b1;
          end else if (is_enter) begin
            state_nxt = S_CHECK;
            ack_nxt   = 1'b1;
          end
        end
      end

      S_CHECK: begin
        entry_nxt = '0;
        count_nxt = '0;
        if (match) begin
          state_nxt = S_OPEN;
          timer_nxt = OPEN_LOAD;
          fail_nxt  = '0;
        end else begin
          fail_nxt = fail_inc;
          if (fail_inc == MAX_FAIL4) begin
            state_nxt = S_LOCKOUT;
            timer_nxt = LOCK_LOAD;
          end else begin
            state_nxt = S_FAIL;
            timer_nxt = ERR_LOAD;
          end
        end
      end

      // A key arriving on the expiry cycle loses to the timer.
      S_OPEN: begin
        if (timer_zero) begin
          state_nxt = S_ENTRY;
        end else begin
          timer_nxt = timer - TW'(1);
          if (key_event && (is_clear || is_enter)) begin
            state_nxt = S_ENTRY;
            ack_nxt   = 1'b1;
          end
        end
      end

      S_FAIL: begin
        if (timer_zero)
          state_nxt = S_ENTRY;
        else
          timer_nxt = timer - TW'(1);
      end

      S_LOCKOUT: begin
        if (timer_zero) begin
          state_nxt = S_ENTRY;
          fail_nxt  = '0;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end

      default: begin
        state_nxt = S_ENTRY;
        entry_nxt = '0;
        count_nxt = '0;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_ENTRY;
      timer       <= '0;
      entry       <= '0;
      digit_count <= '0;
      fail_count  <= '0;
      key_ack     <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      entry       <= entry_nxt;
      digit_count <= count_nxt;
      fail_count  <= fail_nxt;
      key_ack     <= ack_nxt;
    end
  end

  assign unlock  = (state == S_OPEN);
  assign error   = (state == S_FAIL) || (state == S_LOCKOUT);
  assign lockout = (state == S_LOCKOUT);

endmodule

// File: tb/tb_password_checker.sv
// Randomized scoreboard bench for password_checker: a timeline-based reference model
// predicts key acks and unlock/error/lockout windows, a monitor compares them.
module tb_password_checker;

  localparam int          PW_LEN   = 4;
  localparam logic [31:0] PASSWORD = 32'h0000_1234;
  localparam int          DEB      = 2;
  localparam int          OPEN     = 10;
  localparam int          ERR      = 5;
  localparam int          MAXF     = 3;
  localparam int          LOCK     = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  value = 4'd0;
  logic        enable = 1'b0;
  logic        key_ack;
  logic [3:0]  digit_count;
  logic [31:0] entry;
  logic        unlock, error, lockout;
  logic [3:0]  fail_count;

  password_checker #(
    .PW_LEN(PW_LEN), .PASSWORD(PASSWORD), .DEB_CYCLES(DEB), .OPEN_CYCLES(OPEN),
    .ERR_CYCLES(ERR), .MAX_FAIL(MAXF), .LOCK_CYCLES(LOCK)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .enable(enable), .key_ack(key_ack),
    .digit_count(digit_count), .entry(entry), .unlock(unlock), .error(error),
    .lockout(lockout), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  longint edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct { logic [31:0] entry; int count; int fail; } ack_t;
  typedef struct { logic [2:0] pat; longint start; longint len; int fail; } win_t;

  ack_t aq[$];
  win_t wq[$];
  int   checks = 0;
  int   passes = 0;
  bit   win_active = 0;

  // Model: digits typed so far, failure count and the current outcome window on the edge timeline.
  int     mbuf[$];
  int     mfail = 0;
  int     wkind = 0;
  longint wenter = 0;
  longint wdur = 0;

  function automatic void check(string name, longint act, longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic void report_unexpected(string name, longint act);
    checks++;
    $display("[TB] FAIL %s: got 0x%0h, expected nothing", name, act);
  endfunction

  function automatic logic [31:0] model_entry();
    logic [31:0] e = 32'd0;
    foreach (mbuf[i]) e = (e << 4) | 32'(mbuf[i]);
    return e;
  endfunction

  function automatic int model_fail_now(longint now);
    if (wkind == 3 && now >= wenter + LOCK + 1) return 0;
    return mfail;
  endfunction

  function automatic logic [2:0] model_pat_now(longint now);
    if (wkind == 0 || now < wenter + 1 || now > wenter + wdur) return 3'b000;
    if (wkind == 1) return 3'b100;
    if (wkind == 2) return 3'b010;
    return 3'b011;
  endfunction

  function automatic void push_ack(logic [31:0] e, int c, int f);
    ack_t a;
    a.entry = e; a.count = c; a.fail = f;
    aq.push_back(a);
  endfunction

  // A key event consumed at edge x; windows occupy edges x+1 (check) through x+1+duration.
  function automatic void model_event(int code, longint x);
    win_t w;
    bit   ok;
    if (wkind != 0) begin
      if (x <= wenter + 1 + wdur) begin
        if (wkind == 1 && x >= wenter + 2 && x < wenter + 1 + wdur && (code == 10 || code == 11)) begin
          wdur = x - wenter - 1;
          w = wq.pop_back();
          w.len = wdur;
          wq.push_back(w);
          push_ack(32'd0, 0, mfail);
        end
        return;
      end
      if (wkind == 3) mfail = 0;
      wkind = 0;
    end
    if (code <= 9) begin
      if (mbuf.size() < PW_LEN) begin
        mbuf.push_back(code);
        push_ack(model_entry(), mbuf.size(), mfail);
      end
    end else if (code == 10) begin
      mbuf.delete();
      push_ack(32'd0, 0, mfail);
    end else if (code == 11) begin
      push_ack(model_entry(), mbuf.size(), mfail);
      ok = (mbuf.size() == PW_LEN);
      if (ok)
        for (int i = 0; i < PW_LEN; i++)
          if (mbuf[i] != int'((PASSWORD >> (4 * (PW_LEN - 1 - i))) & 32'hF)) ok = 0;
      mbuf.delete();
      wenter = x;
      if (ok) begin
        mfail = 0; wkind = 1; wdur = OPEN; w.pat = 3'b100;
      end else begin
        mfail++;
        if (mfail == MAXF) begin wkind = 3; wdur = LOCK; w.pat = 3'b011; end
        else begin wkind = 2; wdur = ERR; w.pat = 3'b010; end
      end
      w.start = x + 1; w.len = wdur; w.fail = mfail;
      wq.push_back(w);
    end
  endfunction

  task automatic checkOutput(input string tag);
    longint now = edge_n;
    check({tag, "_entry"}, entry, model_entry());
    check({tag, "_count"}, digit_count, mbuf.size());
    check({tag, "_fail"}, fail_count, model_fail_now(now));
    check({tag, "_flags"}, {unlock, error, lockout}, model_pat_now(now));
    check({tag, "_ack"}, key_ack, 0);
  endtask

  // Called just after a negedge: hold the key for 'hold' cycles, release for 'gap'.
  task automatic applyStimulus(input int code, input int hold, input int gap);
    if (hold >= DEB) model_event(code, edge_n + DEB);
    value  = 4'(code);
    enable = 1'b1;
    repeat (hold) @(negedge clk);
    enable = 1'b0;
    value  = 4'($urandom_range(0, 15));
    repeat (gap) @(negedge clk);
    checkOutput("press");
  endtask

  task automatic pressDigits(input logic [31:0] digits, input int n, input int hold, input int gap);
    for (int i = n - 1; i >= 0; i--) applyStimulus(int'((digits >> (4 * i)) & 32'hF), hold, gap);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_ack"}, key_ack, 0);
    check({tag, "_count"}, digit_count, 0);
    check({tag, "_entry"}, entry, 0);
    check({tag, "_flags"}, {unlock, error, lockout}, 0);
    check({tag, "_fail"}, fail_count, 0);
  endtask

  initial begin : monitor
    logic [2:0] pat;
    logic [2:0] wpat;
    longint     wstart;
    int         wfail;
    ack_t       a;
    win_t       w;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        win_active = 0;
      end else begin
        if (key_ack) begin
          if (aq.size() == 0) report_unexpected("ack_unexpected", edge_n);
          else begin
            a = aq.pop_front();
            check("ack_entry", entry, a.entry);
            check("ack_count", digit_count, a.count);
            check("ack_fail", fail_count, a.fail);
          end
        end
        pat = {unlock, error, lockout};
        if (win_active && pat != wpat) begin
          win_active = 0;
          if (wq.size() == 0) report_unexpected("win_unexpected", wpat);
          else begin
            w = wq.pop_front();
            check("win_flags", wpat, w.pat);
            check("win_start", wstart, w.start);
            check("win_len", edge_n - wstart, w.len);
            check("win_fail", wfail, w.fail);
          end
        end
        if (!win_active && pat != 3'b000) begin
          win_active = 1; wpat = pat; wstart = edge_n; wfail = fail_count;
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    int guard;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b1;
    @(negedge clk);

    pressDigits(32'h1234, 4, 5, 3);
    check("t1_entry", entry, 32'h1234);
    check("t1_count", digit_count, 4);
    applyStimulus(11, 5, 3);
    idle(14);
    checkOutput("t1_done");

    applyStimulus(7, 100, 3);
    check("t2_entry", entry, 32'h7);
    check("t2_count", digit_count, 1);
    applyStimulus(10, 3, 2);

    applyStimulus(5, 1, 3);
    pressDigits(32'h12345, 5, 4, 2);
    check("t3_entry", entry, 32'h1234);
    applyStimulus(10, 3, 2);
    check("t3_clr_count", digit_count, 0);
    check("t3_clr_entry", entry, 0);

    pressDigits(32'h123, 3, 5, 3);
    applyStimulus(11, 5, 3);
    check("t4_fail", fail_count, 1);
    idle(4);

    pressDigits(32'h1234, 4, 3, 2);
    applyStimulus(11, 2, 1);
    idle(2);
    applyStimulus(10, 3, 1);
    idle(12);

    for (int k = 0; k < 3; k++) begin
      pressDigits(32'h9999, 4, 3, 2);
      applyStimulus(11, 3, 2);
      idle(6);
    end
    applyStimulus(1, 3, 2);
    applyStimulus(11, 3, 2);
    idle(20);
    check("t6_fail", fail_count, 0);
    pressDigits(32'h1234, 4, 3, 2);
    applyStimulus(11, 3, 2);
    idle(12);

    for (int k = 0; k < 3; k++) begin
      pressDigits(32'h9999, 4, 3, 2);
      applyStimulus(11, 3, 2);
      idle(6);
    end
    checkOutput("t7_locked");
    rst = 1'b0;
    #1;
    checkAllZero("t7_rst");
    mbuf.delete(); mfail = 0; wkind = 0; aq.delete(); wq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pressDigits(32'h1234, 4, 3, 2);
    applyStimulus(11, 3, 2);
    idle(12);

    for (int n = 0; n < 150; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        pressDigits(PASSWORD, PW_LEN, $urandom_range(1, 4), $urandom_range(1, 3));
        applyStimulus(11, $urandom_range(2, 4), $urandom_range(1, 3));
      end else if (r < 4) begin
        int nd;
        nd = $urandom_range(1, 5);
        for (int i = 0; i < nd; i++)
          applyStimulus($urandom_range(0, 9), $urandom_range(1, 4), $urandom_range(1, 3));
        applyStimulus(11, $urandom_range(2, 4), $urandom_range(1, 3));
      end else if (r < 9) begin
        applyStimulus($urandom_range(0, 15), $urandom_range(1, 5), $urandom_range(1, 3));
      end else begin
        idle($urandom_range(1, 20));
      end
    end

    guard = 0;
    while ((aq.size() != 0 || wq.size() != 0 || win_active) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) report_unexpected("drain_timeout", aq.size() + wq.size());
    checkOutput("final");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
